// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding for the countdown timer controller
package timer_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divide-by-CLK_DIV strobe that freezes when disabled
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/countdown_timer_ctl.sv
// countdown_timer_ctl: start/pause/clear FSM with down-counter, one-shot or auto-reload expiry
module countdown_timer_ctl
    import timer_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int CLK_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    input  logic                 reload_mode,
    input  logic [WIDTH-1:0]     sw_time,
    output logic [WIDTH-1:0]     time_set,
    output logic [WIDTH-1:0]     time_left,
    output logic [STATE_W-1:0]   state,
    output logic                 running,
    output logic                 done,
    output logic                 expired,
    output logic                 tick
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] set_q, set_d, left_q, left_d;
    logic             exp_q, exp_d, pre_clr;
    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .clr   (pre_clr),
        .tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        left_d  = left_q;
        exp_d   = 1'b0;
        pre_clr = 1'b0;
        if (clear) begin
            state_d = IDLE;
            left_d  = '0;
            pre_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    set_d   = sw_time;
                    left_d  = sw_time;
                    pre_clr = 1'b1;
                    exp_d   = (sw_time == '0);
                    state_d = (sw_time == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (tick && left_q == ONE) begin
                        exp_d   = 1'b1;
                        left_d  = reload_mode ? set_q : '0;
                        state_d = reload_mode ? RUN : DONE;
                    end else if (tick && left_q > ONE) begin
                        left_d = left_q - ONE;
                    end
                    // a one-shot expiry has already moved us to DONE and outranks pause
                    if (pause && state_d == RUN) state_d = PAUSE;
                end
                default: if (start || pause) state_d = RUN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            left_q  <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            left_q  <= left_d;
            exp_q   <= exp_d;
        end
    end
    assign state     = state_q;
    assign time_set  = set_q;
    assign time_left = left_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign expired   = exp_q;
endmodule

// File: tb/tb_countdown_timer_ctl.sv
// tb_countdown_timer_ctl: directed plan plus random traffic against a cycle-level reference model
module tb_countdown_timer_ctl;
    localparam int W   = 6;
    localparam int DIV = 4;
    logic         clk = 0, reset = 0, start = 0, pause = 0, clear = 0, reload_mode = 0;
    logic [W-1:0] sw_time = '0, time_set, time_left;
    logic [1:0]   state;
    logic         running, done, expired, tick;
    int checks = 0, errors = 0;
    int m_st = 0, m_left = 0, m_set = 0, m_pre = 0, m_exp = 0;
    int exp_at, exp_cnt, done_cnt;

    countdown_timer_ctl #(.WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .reload_mode(reload_mode), .sw_time(sw_time), .time_set(time_set),
        .time_left(time_left), .state(state), .running(running), .done(done),
        .expired(expired), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // States as numbers: 0 idle, 1 run, 2 pause, 3 done; m_pre counts cycles spent running in the current period
    task automatic model_edge();
        bit tk;
        if (reset) begin
            m_st = 0; m_left = 0; m_set = 0; m_pre = 0; m_exp = 0;
        end else begin
            tk = (m_st == 1) && (m_pre == DIV - 1);
            m_exp = 0;
            if (clear) begin
                m_st = 0; m_left = 0; m_pre = 0;
            end else if (m_st == 0 || m_st == 3) begin
                if (start) begin
                    m_set = sw_time; m_left = sw_time; m_pre = 0;
                    if (sw_time == 0) begin m_st = 3; m_exp = 1; end
                    else m_st = 1;
                end
            end else if (m_st == 1) begin
                m_pre = (m_pre + 1) % DIV;
                if (tk) begin
                    if (m_left == 1) begin
                        m_exp = 1;
                        if (reload_mode) m_left = m_set;
                        else begin m_left = 0; m_st = 3; end
                    end else if (m_left > 1) m_left = m_left - 1;
                end
                if (pause && m_st == 1) m_st = 2;
            end else if (start || pause) m_st = 1;
        end
    endtask

    task automatic check_all();
        chk("state", state, m_st);
        chk("time_left", time_left, m_left);
        chk("time_set", time_set, m_set);
        chk("running", running, m_st == 1);
        chk("done", done, m_st == 3);
        chk("expired", expired, m_exp);
        chk("tick", tick, (m_st == 1) && (m_pre == DIV - 1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
        start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        reset = 1;
        step(); step();
        chk("reset_state", state, 0);
        chk("reset_left", time_left, 0);
        reset = 0;
        // one-shot from 3
        sw_time = 3; start = 1; step();
        exp_at = 0; exp_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 4) chk("oneshot_left4", time_left, 2);
            if (i == 8) chk("oneshot_left8", time_left, 1);
            if (expired) begin exp_cnt++; if (exp_at == 0) exp_at = i; end
        end
        chk("oneshot_exp_cycle", exp_at, 12);
        chk("oneshot_exp_count", exp_cnt, 1);
        chk("oneshot_done", done, 1);
        // auto-reload from 2
        reload_mode = 1; sw_time = 2; start = 1; step();
        exp_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (expired) begin exp_cnt++; chk("reload_period", i % 8, 0); end
            if (done) done_cnt++;
        end
        chk("reload_exp_count", exp_cnt, 5);
        chk("reload_no_done", done_cnt, 0);
        clear = 1; step();
        // pause two cycles into the first period, resume ten cycles later
        reload_mode = 0; sw_time = 5; start = 1; step();
        step();
        pause = 1; step();
        chk("pause_state", state, 2);
        repeat (10) step();
        chk("pause_left_frozen", time_left, 5);
        pause = 1; step();
        chk("resume_state", state, 1);
        step();
        chk("resume_left_1", time_left, 5);
        step();
        chk("resume_left_2", time_left, 4);
        // zero start
        clear = 1; step();
        sw_time = 0; start = 1; step();
        chk("zero_exp", expired, 1);
        chk("zero_state", state, 3);
        step();
        chk("zero_exp_once", expired, 0);
        // pause coincident with one-shot expiry
        sw_time = 1; start = 1; step();
        repeat (3) step();
        chk("coll_tick", tick, 1);
        pause = 1; step();
        chk("coll_pause_state", state, 3);
        chk("coll_pause_exp", expired, 1);
        // clear coincident with expiry
        sw_time = 1; start = 1; step();
        repeat (3) step();
        clear = 1; step();
        chk("coll_clear_state", state, 0);
        chk("coll_clear_exp", expired, 0);
        chk("coll_clear_set", time_set, 1);
        // reset mid-run at time_left 5
        sw_time = 7; start = 1; step();
        repeat (8) step();
        chk("prereset_left", time_left, 5);
        reset = 1; step();
        chk("midreset_state", state, 0);
        chk("midreset_set", time_set, 0);
        repeat (3) begin
            step();
            chk("reset_held_exp", expired, 0);
            chk("reset_held_tick", tick, 0);
        end
        reset = 0;
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) reload_mode = ~reload_mode;
            sw_time = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
            step();
        end
        reset = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer_ctl.md
# countdown_timer_ctl

Parametrised countdown timer controller, the successor to the board-level 6-bit seconds timer. It merges the tick generation, control state machine and down-counter into one block. It adds:
- a configurable count width and tick period,
- pause/resume,
- an explicit clear,
- an auto-reload (periodic) mode with a one-cycle expiry strobe.

It sits between the debounced pushbutton/switch inputs and the display/LED logic at board top level.

## Interface
- `WIDTH`, 6: width of `sw_time`, `time_set` and `time_left`.
- `CLK_DIV`, 50_000_000: `clk` cycles per count decrement; must be ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; overrides everything.
- `start` in 1: start/resume request, level sampled each cycle (caller supplies a one-cycle pulse).
- `pause` in 1: pause/resume toggle request, one-cycle pulse.
- `clear` in 1: abort to IDLE, one-cycle pulse.
- `reload_mode` in 1: 0 means one-shot, 1 means auto-reload; sampled at each expiry.
- `sw_time` in `WIDTH`: start value, captured on accepted start.
- `time_set` out `WIDTH`: last captured start value.
- `time_left` out `WIDTH`: remaining count.
- `state` out 2: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `expired` out 1: one-cycle strobe on each count expiry.
- `tick` out 1: one-cycle strobe on each prescaler wrap (RUN only).

## Operation
- Reset values:
  - `state` = IDLE.
  - `time_left` = 0, `time_set` = 0.
  - prescaler = 0.
  - `running`, `done`, `expired` and `tick` all = 0.
- Priority when inputs coincide: `reset` > `clear` > expiry > `start` > `pause`.
- IDLE or DONE, `start`:
  - Capture `time_set` ← `sw_time`, `time_left` ← `sw_time`, prescaler ← 0.
  - If `sw_time` == 0: go to DONE and pulse `expired` in the same transition.
  - Otherwise: go to RUN.
- IDLE, `pause`: ignored.
- DONE, `pause`: ignored.
- RUN:
  - The prescaler counts 0..`CLK_DIV`-1.
  - `tick` is asserted in the cycle the prescaler equals `CLK_DIV`-1; the prescaler then wraps to 0.
  - On `tick` with `time_left` > 1: decrement `time_left`.
  - On `tick` with `time_left` == 1 (expiry):
    - Pulse `expired`.
    - If `reload_mode` = 1: `time_left` ← `time_set` and stay in RUN.
    - If `reload_mode` = 0: `time_left` ← 0 and go to DONE.
  - `pause` in RUN: go to PAUSE. The prescaler value is frozen, not cleared.
- RUN, `pause` in the same cycle as `tick`:
  - The decrement or reload is applied.
  - The next state is PAUSE.
  - Exception: a one-shot expiry goes to DONE (expiry outranks `pause`).
- PAUSE:
  - `pause` or `start` returns to RUN; the prescaler resumes from its frozen value.
  - `sw_time` is not recaptured.
- `clear` in any state:
  - Go to IDLE with `time_left` ← 0 and prescaler ← 0.
  - `time_set` is retained.
  - No `expired` strobe.
- `time_left` never wraps below 0 and never exceeds `2^WIDTH`-1; all arithmetic is `WIDTH` bits, unsigned.
- `done` stays high in DONE until `start`, `clear` or `reset`.

## Timing
- All outputs are registered and change on the `clk` edge following the cause.
- Latencies after `start` is sampled:
  - `state`/`running` update 1 cycle later.
  - The first decrement is visible `CLK_DIV` cycles later.
  - Each later decrement follows every `CLK_DIV` cycles.
- Total run time from a start value N is N × `CLK_DIV` cycles, excluding pauses.
- `expired` and `done` rise on the same edge as `time_left` becomes 0 (one-shot) or reloads (auto-reload).
- `reset` asserted mid-run applies on the next edge and forces all reset values. There is no residual `expired` strobe.

## Structure
- Shared package `timer_pkg`:
  - state enum with encodings IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  - the state width constant.
- One sub-module, `tick_prescaler`:
  - parameter `CLK_DIV`;
  - inputs `clk`, `reset`, `en`, `clr`;
  - output `tick`;
  - counter width `$clog2(CLK_DIV)`.
- The controller FSM and down-counter live in `countdown_timer_ctl`.

## Test plan
All scenarios use `CLK_DIV` = 4 and `WIDTH` = 6.
- One-shot:
  - Stimulus: `sw_time` = 3, `start` pulse.
  - Required: `time_left` goes 3 → 2 → 1 → 0 at cycles 4, 8 and 12 after start.
  - Required: `expired` is high for exactly 1 cycle at cycle 12, and `done` = 1 and `state` = 3 from then on.
- Auto-reload:
  - Stimulus: `reload_mode` = 1, `sw_time` = 2, `start`.
  - Required: `time_left` sequence 2, 1, 2, 1, 2.
  - Required: an `expired` strobe every 8 cycles; `done` never asserts.
- Pause/resume:
  - Stimulus: `pause` 2 cycles into the first tick period, held off for 10 cycles, then `pause` again.
  - Required: the first decrement occurs 2 cycles after resume, and `time_left` is unchanged during PAUSE.
- Zero start:
  - Stimulus: `sw_time` = 0, `start`.
  - Required: the next edge gives DONE with a 1-cycle `expired` and `time_left` = 0.
- Collisions:
  - Stimulus: `pause` coincident with a tick at `time_left` = 1 in one-shot mode.
  - Required: `state` = DONE.
  - Stimulus: `clear` coincident with an expiry tick.
  - Required: IDLE, no `expired` strobe, `time_set` retained.
- Reset mid-run:
  - Stimulus: `reset` asserted with `time_left` = 5 in RUN.
  - Required: the next edge gives all outputs 0, `state` = IDLE, and no strobes while reset is held.
